// File: rtl/perf_cnt_pkg.sv
// Shared mode encoding for the performance counter bank and its channels.
package perf_cnt_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10,
        CNT_RELOAD  = 2'b11
    } cnt_mode_e;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RELOAD  = 2'b11;

endpackage

// File: rtl/perf_cnt_channel.sv
// One counter channel: count, sticky overflow, one-shot halt and compare-match pulse.
module perf_cnt_channel
    import perf_cnt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] cmp_val_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             match_o,
    output logic             ovf_o,
    output logic             halted_o
);

    logic [WIDTH-1:0] count_q, count_d, count_nxt;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d, ovf_set;
    logic             halted_q, halted_d;
    logic             at_max, cmp_hit;
    cnt_mode_e        mode_e;

    assign mode_e    = cnt_mode_e'(mode_i);
    assign count_nxt = count_q + 1'b1;
    assign at_max    = &count_q;
    // A zero compare value disables matching so the channel falls back to wrapping.
    assign cmp_hit   = (cmp_val_i != '0) && (count_nxt == cmp_val_i);

    always_comb begin
        count_d  = count_q;
        match_d  = 1'b0;
        halted_d = halted_q;
        ovf_set  = 1'b0;
        if (clr_i) begin
            count_d  = '0;
            halted_d = 1'b0;
        end else if (en_i && inc_i && !halted_q) begin
            count_d = count_nxt;
            ovf_set = at_max;
            case (mode_e)
                CNT_SAT: begin
                    if (at_max) count_d = count_q;
                end
                CNT_ONESHOT: begin
                    if (cmp_hit) begin
                        count_d  = cmp_val_i;
                        match_d  = 1'b1;
                        halted_d = 1'b1;
                        ovf_set  = 1'b0;
                    end
                end
                CNT_RELOAD: begin
                    if (cmp_hit) begin
                        count_d = '0;
                        match_d = 1'b1;
                        ovf_set = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        ovf_d = ovf_set ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            match_q  <= match_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

    assign count_o  = count_q;
    assign match_o  = match_q;
    assign ovf_o    = ovf_q;
    assign halted_o = halted_q;

endmodule

// File: rtl/perf_event_counter_bank.sv
// Bank of NUM_CH event counters with atomic snapshot shadows and a registered read port.
module perf_event_counter_bank
    import perf_cnt_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       inc,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH*WIDTH-1:0] cmp_val,
    input  logic [NUM_CH-1:0]       ovf_clr,
    input  logic                    snap,
    input  logic                    rd_req,
    input  logic [CH_W-1:0]         rd_ch,
    input  logic                    rd_shadow,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       match,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       halted,
    output logic                    rd_valid,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] shadow_q [NUM_CH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_cnt_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en[i]),
            .inc_i     (inc[i]),
            .clr_i     (clr[i]),
            .mode_i    (mode[2*i +: 2]),
            .cmp_val_i (cmp_val[WIDTH*i +: WIDTH]),
            .ovf_clr_i (ovf_clr[i]),
            .count_o   (count[WIDTH*i +: WIDTH]),
            .match_o   (match[i]),
            .ovf_o     (ovf[i]),
            .halted_o  (halted[i])
        );
    end

    // Snapshot samples the registered counts, i.e. the values before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
        end else if (snap) begin
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= count[WIDTH*i +: WIDTH];
        end
    end

    // Out-of-range channel numbers match no loop index and read as zero.
    always_comb begin
        rd_data_d = '0;
        if (rd_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_ch == CH_W'(i)) begin
                    rd_data_d = rd_shadow ? shadow_q[i] : count[WIDTH*i +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Directed bench for perf_event_counter_bank with scoreboarded reads and match pulses.
module tb_perf_event_counter_bank;
    import perf_cnt_pkg::*;

    localparam int NUM_CH = 5;
    localparam int WIDTH  = 8;
    localparam int CH_W   = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en, inc, clr, ovf_clr;
    logic [2*NUM_CH-1:0]     mode;
    logic [NUM_CH*WIDTH-1:0] cmp_val;
    logic                    snap, rd_req, rd_shadow;
    logic [CH_W-1:0]         rd_ch;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       match, ovf, halted;
    logic                    rd_valid;
    logic [WIDTH-1:0]        rd_data;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int mcnt [NUM_CH];
    logic [WIDTH-1:0] rd_q [$];
    int m2_q [$];
    int m3_q [$];

    perf_event_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr), .mode(mode),
        .cmp_val(cmp_val), .ovf_clr(ovf_clr), .snap(snap), .rd_req(rd_req),
        .rd_ch(rd_ch), .rd_shadow(rd_shadow), .count(count), .match(match),
        .ovf(ovf), .halted(halted), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int i);
        return count[WIDTH*i +: WIDTH];
    endfunction

    task automatic rd(input int ch, input logic shd, input logic [WIDTH-1:0] exp);
        rd_req    = 1'b1;
        rd_ch     = CH_W'(ch);
        rd_shadow = shd;
        rd_q.push_back(exp);
        step();
    endtask

    // Monitor: outputs sampled mid-cycle, compared against queued expectations.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) if (match[i] === 1'b1) mcnt[i]++;
        if (match[2] === 1'b1) begin
            if (m2_q.size() == 0) chk("match2_unexpected", n_done, 0);
            else chk("match2_at_inc", n_done, m2_q.pop_front());
        end
        if (match[3] === 1'b1) begin
            if (m3_q.size() == 0) chk("match3_unexpected", n_done, 0);
            else chk("match3_at_inc", n_done, m3_q.pop_front());
        end
        if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
            else chk("rd_data", rd_data, rd_q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) mcnt[i] = 0;
        rst = 1'b1; en = '0; inc = '0; clr = '0; ovf_clr = '0; snap = 1'b0;
        rd_req = 1'b0; rd_ch = '0; rd_shadow = 1'b0;
        mode    = {MODE_WRAP, MODE_RELOAD, MODE_ONESHOT, MODE_SAT, MODE_WRAP};
        cmp_val = {8'd0, 8'd5, 8'd10, 8'd0, 8'd0};
        step();
        chk("rst_count", count, 0);
        chk("rst_match", match, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rd_valid", rd_valid, 0);
        rst = 1'b0;
        en  = '1;

        // WRAP: 260 increments wrap once
        inc = 5'b00001;
        repeat (260) step();
        inc = '0;
        chk("wrap_count0", cnt(0), 4);
        chk("wrap_ovf0", ovf[0], 1);
        chk("wrap_nomatch0", mcnt[0], 0);

        // SAT
        inc = 5'b00010;
        repeat (300) step();
        inc = '0;
        chk("sat_count1", cnt(1), 255);
        chk("sat_ovf1", ovf[1], 1);
        ovf_clr = 5'b00010; step(); ovf_clr = '0;
        chk("sat_ovf1_cleared", ovf[1], 0);
        inc = 5'b00010; step(); inc = '0;
        chk("sat_ovf1_reset", ovf[1], 1);
        chk("sat_count1_hold", cnt(1), 255);
        ovf_clr = 5'b00010; step();
        chk("sat_ovf1_cleared2", ovf[1], 0);
        inc = 5'b00010; step(); inc = '0; ovf_clr = '0;
        chk("sat_set_beats_clr", ovf[1], 1);
        chk("sat_nomatch1", mcnt[1], 0);

        // ONESHOT cmp=10
        m2_q.push_back(10);
        inc = 5'b00100;
        for (int n = 1; n <= 15; n++) begin step(); n_done = n; end
        inc = '0;
        chk("os_count2", cnt(2), 10);
        chk("os_halted2", halted[2], 1);
        chk("os_match_cnt2", mcnt[2], 1);
        clr = 5'b00100; step(); clr = '0;
        chk("os_clr_count2", cnt(2), 0);
        chk("os_clr_halted2", halted[2], 0);
        cmp_val[16 +: 8] = 8'd0;
        inc = 5'b00100;
        repeat (3) step();
        inc = '0;
        chk("os_cmp0_count2", cnt(2), 3);
        chk("os_cmp0_nomatch", mcnt[2], 1);

        // RELOAD cmp=5
        m3_q.push_back(5); m3_q.push_back(10); m3_q.push_back(15); m3_q.push_back(20);
        inc = 5'b01000;
        for (int n = 1; n <= 20; n++) begin step(); n_done = n; end
        inc = '0;
        step();
        chk("rl_match_cnt3", mcnt[3], 4);
        chk("rl_count3", cnt(3), 0);
        chk("rl_ovf3", ovf[3], 0);
        chk("rl_queue_drained", m3_q.size(), 0);

        // Snapshot with simultaneous clear, then reads
        clr = 5'b00010; step(); clr = '0;
        inc = 5'b00010; repeat (7) step(); inc = '0;
        chk("pre_snap_count1", cnt(1), 7);
        snap = 1'b1; clr = 5'b00010; step(); snap = 1'b0; clr = '0;
        chk("snap_clr_count1", cnt(1), 0);
        rd(1, 1'b1, 8'd7);
        rd(0, 1'b0, 8'd4);
        rd(2, 1'b0, 8'd3);
        rd(2, 1'b1, 8'd3);
        rd(6, 1'b0, 8'd0);
        rd_req = 1'b0;
        step();
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("rd_valid_idle", rd_valid, 0);

        // Halt ch2 then reset mid-operation with a read pending
        cmp_val[16 +: 8] = 8'd4;
        m2_q.push_back(1);
        n_done = 0;
        inc = 5'b00100; step(); n_done = 1; inc = '0;
        chk("os2_halted_before_rst", halted[2], 1);
        chk("os2_count_before_rst", cnt(2), 4);
        rd(0, 1'b0, 8'd4);
        rst = 1'b1; inc = '1; rd_req = 1'b1; rd_ch = 3'd0; rd_shadow = 1'b0;
        step();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_match", match, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        rst = 1'b0; rd_req = 1'b0; inc = 5'b00001;
        repeat (3) step();
        inc = '0;
        chk("post_rst_count0", cnt(0), 3);
        chk("post_rst_count1", cnt(1), 0);
        rd(1, 1'b1, 8'd0);
        rd_req = 1'b0;
        step();
        chk("final_rd_drained", rd_q.size(), 0);
        chk("final_m2_drained", m2_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
